uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 141 ++++++++++++++
 tb/tb_uart_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART receiver with 16x oversampling and majority-vote bit
// resolution.
//   Clk         in   system clock (50 MHz), rising edge
//   reset       in   asynchronous active-high reset
//   baud_select in   [2:0] oversample divider select, latched at start detection
//   Rx_EN       in   receiver enable; dropping it mid-frame aborts the frame
//   RxD         in   serial line (idle 1), asynchronous to Clk
//   Rx_DATA     out  [7:0] last received byte (loaded at stop, even on error)
//   Rx_VALID    out  one-cycle pulse after an error-free frame
//   Rx_PERROR   out  even-parity error, held until next confirmed start bit
//   Rx_FERROR   out  framing (stop bit = 0) error, held until next confirmed start
module uart_receiver (
  input  logic       Clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_next;
  logic        rx_s1, rx_s2, rx_prev;
  logic [2:0]  baud_q;
  logic [13:0] div_cnt, div_max;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        parity_acc;
  logic [1:0]  votes;
  logic        tick, resolve, vote, start_edge;

  // Divider terminal count (N-1) for the frame's latched baud select.
  always_comb begin
    div_max = 14'd26;
    case (baud_q)
      3'b000: div_max = 14'd10416;
      3'b001: div_max = 14'd2603;
      3'b010: div_max = 14'd650;
      3'b011: div_max = 14'd325;
      3'b100: div_max = 14'd162;
      3'b101: div_max = 14'd80;
      3'b110: div_max = 14'd53;
      3'b111: div_max = 14'd26;
    endcase
  end

  assign tick       = (div_cnt == div_max);
  assign resolve    = tick && (tick_cnt == 4'd9);
  // Majority of the samples taken at ticks 7, 8 and the live tick-9 sample.
  assign vote       = (votes[1] & votes[0]) | (votes[1] & rx_s2) | (votes[0] & rx_s2);
  // rx_prev must have seen a synchronized 1, so a line held low never restarts.
  assign start_edge = rx_prev & ~rx_s2;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state != IDLE && !Rx_EN) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (Rx_EN && start_edge) state_next = START;
        START:   if (resolve) state_next = vote ? IDLE : DATA;
        DATA:    if (resolve && bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  if (resolve) state_next = STOP;
        STOP:    if (resolve) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      baud_q     <= '1;
      div_cnt    <= '1;
      tick_cnt   <= '1;
      bit_cnt    <= '1;
      shift_reg  <= '1;
      parity_acc <= 1'b1;
      votes      <= '1;
      Rx_DATA    <= '0;
      Rx_VALID   <= 1'b0;
      Rx_PERROR  <= 1'b0;
      Rx_FERROR  <= 1'b0;
    end else begin
      rx_s1    <= RxD;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      Rx_VALID <= 1'b0;
      if (state == IDLE) begin
        if (Rx_EN && start_edge) begin
          baud_q     <= baud_select;
          div_cnt    <= '0;
          tick_cnt   <= '0;
          bit_cnt    <= '0;
          parity_acc <= 1'b0;
        end
      end else if (Rx_EN) begin
        div_cnt <= tick ? '0 : div_cnt + 14'd1;
        if (tick) tick_cnt <= tick_cnt + 4'd1;
        if (tick && tick_cnt == 4'd7) votes[1] <= rx_s2;
        if (tick && tick_cnt == 4'd8) votes[0] <= rx_s2;
        if (resolve) begin
          case (state)
            START: begin
              if (!vote) begin
                Rx_PERROR <= 1'b0;
                Rx_FERROR <= 1'b0;
              end
            end
            DATA: begin
              shift_reg  <= {vote, shift_reg[7:1]};
              parity_acc <= parity_acc ^ vote;
              bit_cnt    <= bit_cnt + 3'd1;
            end
            PARITY: parity_acc <= parity_acc ^ vote;
            STOP: begin
              Rx_DATA   <= shift_reg;
              Rx_PERROR <= parity_acc;
              Rx_FERROR <= ~vote;
              Rx_VALID  <= ~parity_acc & vote;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;
  localparam int N   = 27;
  localparam int BIT = 16 * N;

  logic       Clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

  always #10 Clk = ~Clk;

  uart_receiver dut (
    .Clk(Clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
    .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
  );

  int         total = 0;
  int         bad   = 0;
  int         vcount = 0;
  logic [7:0] vdata = '0;
  longint     cyc_cnt = 0, vcycle = 0, edge_cyc = 0;
  logic       vprev = 1'b0;

  // Reference state: what the receiver outputs should read between frames.
  logic [7:0] exp_data;
  logic       exp_perr, exp_ferr;

  // Every valid pulse must be one cycle wide and never coincide with an error flag.
  always @(negedge Clk) begin
    cyc_cnt++;
    if (Rx_VALID === 1'b1) begin
      vcount++;
      vdata  = Rx_DATA;
      vcycle = cyc_cnt;
      total++;
      if (vprev || Rx_PERROR || Rx_FERROR) begin
        bad++;
        $display("FAIL valid_pulse: got prev_valid=%0b perr=%0b ferr=%0b want 0 0 0",
                 vprev, Rx_PERROR, Rx_FERROR);
      end
    end
    vprev = Rx_VALID;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input logic stop,
                           input int idle, input logic scramble_baud,
                           input logic [7:0] ed, input logic ev, input logic ep, input logic ef);
    logic [10:0] bits;
    int v0;
    bits = {stop, par, d, 1'b0};
    v0 = vcount;
    RxD = 1'b0;
    edge_cyc = cyc_cnt;
    cyc(BIT);
    chk("start_clears_perr", 32'(Rx_PERROR), 32'(0));
    chk("start_clears_ferr", 32'(Rx_FERROR), 32'(0));
    chk("data_held_in_frame", 32'(Rx_DATA), 32'(exp_data));
    if (scramble_baud) baud_select = 3'($urandom_range(0, 6));
    for (int i = 1; i < 11; i++) begin
      RxD = bits[i];
      cyc(BIT);
    end
    baud_select = 3'b111;
    chk("rx_data", 32'(Rx_DATA), 32'(ed));
    chk("valid_count", 32'(vcount - v0), 32'(ev));
    chk("perror", 32'(Rx_PERROR), 32'(ep));
    chk("ferror", 32'(Rx_FERROR), 32'(ef));
    if (ev) begin
      chk("valid_data", 32'(vdata), 32'(ed));
      chk("valid_in_stop_bit",
          32'((vcycle - edge_cyc >= longint'(10 * BIT)) && (vcycle - edge_cyc <= longint'(11 * BIT))),
          32'(1));
    end
    exp_data = ed;
    exp_perr = ep;
    exp_ferr = ef;
    if (idle > 0) begin
      RxD = 1'b1;
      cyc(idle);
    end
  endtask

  // Send start bit plus data bits 0..3, then stop halfway into data bit 4.
  task automatic partial_frame(input logic [7:0] d);
    RxD = 1'b0;
    cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      RxD = d[i];
      cyc(BIT);
    end
    RxD = d[4];
    cyc(BIT / 2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         idle;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int v0;
    logic [7:0] d;
    logic flip, stop, perr, ferr, par;

    tbl[0] = '{8'h8A, 1'b1, 1'b1, 0, 8'h8A, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b0, 1'b1, 0, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h8A, 1'b0, 1'b1, 0, 8'h8A, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h3C, 1'b0, 1'b1, 0, 8'h3C, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h55, 1'b0, 1'b0, 0, 8'h55, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    RxD = 1'b1;
    Rx_EN = 1'b1;
    baud_select = 3'b111;
    cyc(3);
    chk("reset_data", 32'(Rx_DATA), 32'(0));
    chk("reset_valid", 32'(Rx_VALID), 32'(0));
    chk("reset_perr", 32'(Rx_PERROR), 32'(0));
    chk("reset_ferr", 32'(Rx_FERROR), 32'(0));
    reset = 1'b0;
    exp_data = 8'h00;
    exp_perr = 1'b0;
    exp_ferr = 1'b0;
    cyc(BIT);

    // Good, back-to-back, parity error, recovery, framing error.
    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].idle, 1'b0,
                tbl[i].exp_data, tbl[i].exp_valid, tbl[i].exp_perr, tbl[i].exp_ferr);

    // Line stays low after the framing error: no new start may be seen.
    v0 = vcount;
    cyc(2 * BIT);
    chk("low_line_no_valid", 32'(vcount - v0), 32'(0));
    chk("low_line_ferr_held", 32'(Rx_FERROR), 32'(1));
    chk("low_line_data_held", 32'(Rx_DATA), 32'(8'h55));
    RxD = 1'b1;
    cyc(BIT);

    // Random frames against the frame-rule model; baud_select wiggles mid-frame.
    for (int k = 0; k < 3; k++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      par  = (^d) ^ flip;
      perr = (^d) ^ par;
      ferr = ~stop;
      run_frame(d, par, stop, stop ? $urandom_range(0, 2) * N : N + $urandom_range(0, N),
                1'b1, d, ~perr & ~ferr, perr, ferr);
    end
    RxD = 1'b1;
    cyc(BIT);

    // Short low glitch at 9600 Bd divider: rejected in START, nothing changes.
    baud_select = 3'b011;
    v0 = vcount;
    RxD = 1'b0;
    cyc(4 * 326);
    RxD = 1'b1;
    cyc(12 * 326);
    baud_select = 3'b111;
    chk("glitch_no_valid", 32'(vcount - v0), 32'(0));
    chk("glitch_data", 32'(Rx_DATA), 32'(exp_data));
    chk("glitch_perr", 32'(Rx_PERROR), 32'(exp_perr));
    chk("glitch_ferr", 32'(Rx_FERROR), 32'(exp_ferr));
    run_frame(8'hA5, 1'b0, 1'b1, BIT, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);

    // Enable dropped in data bit 4: frame abandoned, outputs hold.
    v0 = vcount;
    partial_frame(8'hC3);
    Rx_EN = 1'b0;
    cyc(2);
    RxD = 1'b1;
    cyc(7 * BIT);
    chk("en_drop_no_valid", 32'(vcount - v0), 32'(0));
    chk("en_drop_data", 32'(Rx_DATA), 32'(8'hA5));
    chk("en_drop_perr", 32'(Rx_PERROR), 32'(0));
    chk("en_drop_ferr", 32'(Rx_FERROR), 32'(0));
    Rx_EN = 1'b1;
    cyc(BIT);
    run_frame(8'h96, 1'b0, 1'b1, BIT, 1'b0, 8'h96, 1'b1, 1'b0, 1'b0);

    // Reset in data bit 4: outputs clear immediately, no pulse.
    v0 = vcount;
    partial_frame(8'hE7);
    reset = 1'b1;
    #1;
    chk("async_reset_data", 32'(Rx_DATA), 32'(0));
    chk("async_reset_valid", 32'(Rx_VALID), 32'(0));
    cyc(3);
    RxD = 1'b1;
    reset = 1'b0;
    exp_data = 8'h00;
    cyc(7 * BIT);
    chk("reset_abort_no_valid", 32'(vcount - v0), 32'(0));
    chk("reset_abort_data", 32'(Rx_DATA), 32'(0));
    chk("reset_abort_perr", 32'(Rx_PERROR), 32'(0));
    run_frame(8'h81, 1'b0, 1'b1, BIT, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
